// File: rtl/mac_pkg.sv
// mac_pkg: shared widths, operand types and serialiser states for the MAC operand path.
package mac_pkg;
    localparam int DEF_DATA_W = 64;
    localparam int DEF_ELEM_W = 8;
    localparam int DEF_DEPTH  = 4;
    typedef logic [DEF_DATA_W-1:0] word_t;
    typedef logic [DEF_ELEM_W-1:0] elem_t;
    typedef enum logic {IDLE, SHIFT} ser_state_e;
endpackage

// File: rtl/rv_word_fifo.sv
// rv_word_fifo: DEPTH x W word FIFO with valid/ready push and pop and an occupancy count.
module rv_word_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [W-1:0]               push_data,
    output logic                       pop_valid,
    input  logic                       pop_ready,
    output logic [W-1:0]               pop_data,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rdy_q, rdy_d, push, pop;
    // rdy_q keeps push_ready low until the first edge after reset release
    assign push_ready = rdy_q && (count_q != CW'(DEPTH));
    assign pop_valid  = count_q != '0;
    assign push       = push_valid && push_ready;
    assign pop        = pop_valid && pop_ready;
    assign pop_data   = mem_q[rd_ptr_q];
    assign count      = count_q;
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        rdy_d    = 1'b1;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdy_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdy_q    <= rdy_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end
endmodule

// File: rtl/mac_operand_unpacker.sv
// mac_operand_unpacker: buffers DATA_W words and serialises them LSB-first into ELEM_W operands.
module mac_operand_unpacker
    import mac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ELEM_W = DEF_ELEM_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ELEM_W-1:0]        out_elem,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int N  = DATA_W / ELEM_W;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    if (DATA_W % ELEM_W != 0) begin : g_bad_width
        $error("DATA_W must be a multiple of ELEM_W");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two >= 2");
    end
    ser_state_e        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d, fifo_data;
    logic [IW-1:0]     idx_q, idx_d;
    logic              fifo_valid, take, pop, beat;
    assign out_valid = state_q == SHIFT;
    assign beat      = out_valid && out_ready;
    assign out_last  = out_valid && (idx_q == IW'(N - 1));
    assign out_elem  = shift_q[ELEM_W-1:0];
    // reload on the final beat so consecutive words stream without a bubble
    assign take      = (state_q == IDLE) || (beat && out_last);
    assign pop       = fifo_valid && take;
    rv_word_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_valid(in_valid),
        .push_ready(in_ready),
        .push_data (in_data),
        .pop_valid (fifo_valid),
        .pop_ready (take),
        .pop_data  (fifo_data),
        .count     (fifo_count)
    );
    always_comb begin
        state_d = pop ? SHIFT : (beat && out_last) ? IDLE : state_q;
        idx_d   = pop ? '0 : beat ? idx_q + IW'(1) : idx_q;
        shift_d = pop ? fifo_data : beat ? shift_q >> ELEM_W : shift_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end
endmodule

// File: tb/tb_mac_operand_unpacker.sv
// tb_mac_operand_unpacker: directed and burst stimulus with a queue scoreboard on the operand stream.
module tb_mac_operand_unpacker;
    logic        clk = 1'b0, reset = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_ready, out_valid, out_last;
    logic [7:0]  out_elem, e0;
    logic [2:0]  fifo_count;
    logic [8:0]  exp_q[$];
    logic [8:0]  got, want;
    int          checks = 0, errors = 0;
    bit          rand_rdy = 0;

    mac_operand_unpacker dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_elem(out_elem), .out_last(out_last),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic exp_word(input logic [63:0] w);
        for (int i = 0; i < 8; i++) exp_q.push_back({i == 7, w[i*8 +: 8]});
    endtask

    task automatic push(input logic [63:0] w);
        bit ok = 0;
        in_valid = 1'b1;
        in_data  = w;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (ok) exp_word(w);
        else begin
            checks++;
            errors++;
            $display("FAIL push_timeout: word %0h never accepted", w);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic count_run(input string nm, input int exp);
        int n = 0;
        for (int t = 0; t < 40 && out_valid; t++) begin
            n++;
            step(1);
        end
        chk(nm, n, exp);
    endtask

    task automatic wait_drain(input string nm);
        for (int t = 0; t < 4000 && (exp_q.size() != 0 || out_valid); t++) step(1);
        chk(nm, exp_q.size(), 0);
        chk({nm, "_idle"}, out_valid, 1'b0);
    endtask

    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            checks++;
            got = {out_last, out_elem};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: got last=%0b elem=%0h with empty scoreboard", out_last, out_elem);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL beat: got last=%0b elem=%0h expected last=%0b elem=%0h",
                             got[8], got[7:0], want[8], want[7:0]);
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        step(2);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_out_elem", out_elem, 8'h00);
        chk("rst_fifo_count", fifo_count, 3'd0);
        chk("rst_in_ready", in_ready, 1'b0);
        reset = 1'b1;
        #1;
        chk("release_in_ready_low", in_ready, 1'b0);
        step(1);
        chk("release_in_ready_high", in_ready, 1'b1);

        out_ready = 1'b1;
        push(64'hDEADBEEFCAFEBABE);
        in_valid = 1'b0;
        chk("lat_not_yet", out_valid, 1'b0);
        step(1);
        chk("lat_valid", out_valid, 1'b1);
        chk("lat_first_elem", out_elem, 8'hBE);
        count_run("single_run_len", 8);

        push(64'h0706050403020100);
        push(64'h0F0E0D0C0B0A0908);
        in_valid = 1'b0;
        count_run("b2b_run_len", 16);

        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) push(64'h0706050403020100 + 64'(k) * 64'h1010101010101010);
        chk("bp_count_full", fifo_count, 3'd4);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_first_elem", out_elem, 8'h10);
        e0 = out_elem;
        in_data = 64'hBAD0BAD0BAD0BAD0;
        step(3);
        chk("bp_elem_stable", out_elem, e0);
        chk("bp_valid_held", out_valid, 1'b1);
        chk("bp_count_held", fifo_count, 3'd4);
        chk("bp_sixth_blocked", in_ready, 1'b0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain("bp_drain");

        out_ready = 1'b0;
        push(64'hA7A6A5A4A3A2A1A0);
        push(64'hB7B6B5B4B3B2B1B0);
        push(64'hC7C6C5C4C3C2C1C0);
        in_valid = 1'b0;
        chk("pp_count_pre", fifo_count, 3'd2);
        out_ready = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (out_last) break;
        end
        chk("pp_at_last", out_last, 1'b1);
        chk("pp_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = 64'hD7D6D5D4D3D2D1D0;
        exp_word(64'hD7D6D5D4D3D2D1D0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("pp_count_same", fifo_count, 3'd2);
        wait_drain("pp_drain");

        rand_rdy = 1;
        for (int w = 0; w < 200; w++) begin
            push({$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                step($urandom_range(1, 4));
            end
        end
        in_valid = 1'b0;
        rand_rdy = 0;
        #2;
        out_ready = 1'b1;
        wait_drain("rand_drain");

        out_ready = 1'b0;
        push(64'h0123456789ABCDEF);
        push(64'h1122334455667788);
        push(64'h99AABBCCDDEEFF00);
        in_valid = 1'b0;
        out_ready = 1'b1;
        step(3);
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_out_last", out_last, 1'b0);
        chk("mid_rst_count", fifo_count, 3'd0);
        chk("mid_rst_in_ready", in_ready, 1'b0);
        step(2);
        chk("mid_rst_held_ready", in_ready, 1'b0);
        reset = 1'b1;
        step(1);
        chk("mid_rst_release_ready", in_ready, 1'b1);
        chk("mid_rst_no_leftover", out_valid, 1'b0);
        push(64'h5A5B5C5D5E5F6061);
        in_valid = 1'b0;
        wait_drain("post_rst_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
